sram_async_ctrl: RTL

//  Synthesizable, parametrised controller for an external asynchronous SRAM (IS61LV25616 class).

---
 rtl/sram_async_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_async_ctrl.sv
// rtl/sram_async_ctrl.sv - asynchronous SRAM controller, bus word split into big-endian SRAM beats
module sram_async_ctrl #(
  parameter int BUS_W   = 32,
  parameter int DQ_W    = 16,
  parameter int SRAM_AW = 18,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1,
  localparam int BEATS  = BUS_W / DQ_W,
  localparam int BW     = $clog2(BEATS),
  localparam int AW     = SRAM_AW - BW,
  localparam int SW     = BUS_W / 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [BUS_W-1:0]   wdata_i,
  input  logic [SW-1:0]      sel_i,
  output logic               ack_o,
  output logic [BUS_W-1:0]   rdata_o,
  output logic               busy_o,
  output logic [SRAM_AW-1:0] sram_a_o,
  output logic [DQ_W-1:0]    sram_dq_o,
  input  logic [DQ_W-1:0]    sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n
);

  // Beat counter keeps at least one bit so a single-beat build still elaborates.
  localparam int BI = (BW > 0) ? BW : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RECOVER,
    S_DONE
  } state_t;

  state_t state, state_nx;
  logic [BI-1:0] beat, beat_nx;
  logic [7:0]    cnt, cnt_nx;

  logic               we_q;
  logic [AW-1:0]      addr_q;
  logic [BUS_W-1:0]   wdata_q;
  logic [SW-1:0]      sel_q;
  logic [BUS_W-1:0]   rbuf;

  logic               accept;
  logic [7:0]         wait_last;
  logic [31:0]        shamt;
  logic [DQ_W-1:0]    wslice;
  logic [1:0]         lane_sel;
  logic [1:0]         lanes_on;
  logic               wr_active;
  logic [SRAM_AW-1:0] a_beat;
  logic [BUS_W-1:0]   slice_mask;

  logic [SRAM_AW-1:0] a_nx;
  logic [DQ_W-1:0]    dq_nx;
  logic               ce_nx, oe_nx, we_nx, lb_nx, ub_nx, dq_oe_nx, ack_nx;

  // The cycle carrying ack_o is not an accept slot, so a held req is not taken twice.
  assign accept     = (state == S_IDLE) && req_i && !ack_o;
  assign wait_last  = we_q ? 8'(WR_WAIT - 1) : 8'(RD_WAIT - 1);
  // Beat 0 is the most-significant slice.
  assign shamt      = 32'((BEATS - 1 - int'(beat)) * DQ_W);
  assign wslice     = DQ_W'(wdata_q >> shamt);
  assign lane_sel   = 2'(sel_q >> (shamt / 8));
  assign lanes_on   = we_q ? lane_sel : 2'b11;
  assign wr_active  = we_q && (|lane_sel);
  assign slice_mask = BUS_W'({DQ_W{1'b1}}) << shamt;

  if (BW == 0) begin : g_single
    assign a_beat = addr_q;
  end else begin : g_multi
    assign a_beat = {addr_q, beat};
  end

  // Next-state sequencing: SETUP, ACCESS x wait, RECOVER per beat, then DONE.
  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_SETUP;
          beat_nx  = '0;
        end
      end
      S_SETUP: begin
        cnt_nx   = '0;
        state_nx = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt == wait_last) state_nx = S_RECOVER;
        else                  cnt_nx   = cnt + 8'd1;
      end
      S_RECOVER: begin
        if (beat == BI'(BEATS - 1)) begin
          state_nx = S_DONE;
        end else begin
          beat_nx  = beat + 1'b1;
          state_nx = S_SETUP;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Pad strobes for the current state; they are registered, so the pins trail the state by one cycle.
  always_comb begin
    a_nx     = sram_a_o;
    dq_nx    = sram_dq_o;
    ce_nx    = 1'b1;
    oe_nx    = 1'b1;
    we_nx    = 1'b1;
    lb_nx    = 1'b1;
    ub_nx    = 1'b1;
    dq_oe_nx = 1'b0;
    ack_nx   = 1'b0;
    case (state)
      S_SETUP: begin
        a_nx  = a_beat;
        ce_nx = 1'b0;
        lb_nx = ~lanes_on[0];
        ub_nx = ~lanes_on[1];
      end
      S_ACCESS: begin
        a_nx  = a_beat;
        ce_nx = 1'b0;
        lb_nx = ~lanes_on[0];
        ub_nx = ~lanes_on[1];
        if (!we_q) begin
          oe_nx = 1'b0;
        end else if (wr_active) begin
          we_nx    = 1'b0;
          dq_oe_nx = 1'b1;
          dq_nx    = wslice;
        end
      end
      S_RECOVER: begin
        a_nx     = a_beat;
        ce_nx    = 1'b0;
        lb_nx    = ~lanes_on[0];
        ub_nx    = ~lanes_on[1];
        dq_oe_nx = wr_active;
      end
      S_DONE:  ack_nx = 1'b1;
      default: ;
    endcase
  end

  // State, request latch, read capture and registered pad outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      beat       <= '0;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      rbuf       <= '0;
      rdata_o    <= '0;
      ack_o      <= 1'b0;
      busy_o     <= 1'b0;
      sram_a_o   <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
    end else begin
      state      <= state_nx;
      beat       <= beat_nx;
      cnt        <= cnt_nx;
      ack_o      <= ack_nx;
      busy_o     <= (state != S_IDLE);
      sram_a_o   <= a_nx;
      sram_dq_o  <= dq_nx;
      sram_dq_oe <= dq_oe_nx;
      sram_ce_n  <= ce_nx;
      sram_oe_n  <= oe_nx;
      sram_we_n  <= we_nx;
      sram_lb_n  <= lb_nx;
      sram_ub_n  <= ub_nx;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        sel_q   <= sel_i;
      end
      // The edge leaving RECOVER closes the last pin-level ACCESS cycle of the beat.
      if (state == S_RECOVER && !we_q)
        rbuf <= (rbuf & ~slice_mask) | (BUS_W'(sram_dq_i) << shamt);
      if (state == S_DONE && !we_q)
        rdata_o <= rbuf;
    end
  end

endmodule
